// File: rtl/stack_seq.sv
// stack_seq: control sequencer for CALL, RET, INT and RTI.
// Drives the stack memory controls, the PC/decode freezes, pc_sel and flush.
// Saved PCs take PC_WORDS stack words. An interrupt also saves one CCR word.
// An interrupt that arrives while a sequence is running is latched and
// serviced once the sequencer is back in IDLE.
module stack_seq #(
  parameter int unsigned PC_WORDS  = 2,
  parameter int unsigned INT_DRAIN = 4,
  parameter int unsigned RET_WAIT  = 2,
  parameter int unsigned SEL_W     = $clog2(PC_WORDS + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             call,
  input  logic             ret,
  input  logic             rti,
  input  logic             interrupt,
  input  logic             ldm,
  input  logic             load_use,
  input  logic             branch_taken,
  output logic             ack,
  output logic             stack,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [SEL_W-1:0] push_sel,
  output logic [SEL_W-1:0] pop_sel,
  output logic             freeze_pc,
  output logic             freeze_cu,
  output logic [1:0]       pc_sel,
  output logic             flush,
  output logic             busy
);

  typedef enum logic [2:0] {StIdle, StDrain, StWait, StPush, StPop} state_e;

  localparam logic [4:0] DrainLast    = 5'(INT_DRAIN - 1);
  localparam logic [4:0] WaitLast     = 5'(RET_WAIT - 1);
  localparam logic [4:0] PcLast       = 5'(PC_WORDS - 1);  // last cycle of CALL push / RET pop
  localparam logic [4:0] CcrLast      = 5'(PC_WORDS);      // last cycle of INT push / RTI pop
  localparam logic [4:0] CcrSel       = 5'(PC_WORDS + 1);
  localparam logic [4:0] PcTopSel     = 5'(PC_WORDS);
  localparam bit         RetSkipsWait = (RET_WAIT == 0);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  // kind_q: 1 = INT push / RTI pop (CCR included), 0 = CALL push / RET pop
  logic       kind_q, kind_d;
  // ext_q: a stall was seen in the first drain cycle, so drain one cycle longer
  logic       ext_q, ext_d;
  logic       int_pend_q, int_pend_d;
  logic [4:0] drain_last;

  assign drain_last = ext_q ? DrainLast + 5'd1 : DrainLast;

  // State, counter and pending-interrupt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      kind_q     <= 1'b0;
      ext_q      <= 1'b0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      ext_q      <= ext_d;
      int_pend_q <= int_pend_d;
    end
  end

  // Next-state logic: request arbitration in IDLE, per-state cycle counting elsewhere
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 5'd1;
    kind_d     = kind_q;
    ext_d      = ext_q;
    int_pend_d = int_pend_q | interrupt;
    case (state_q)
      StIdle: begin
        cnt_d      = 5'd0;
        ext_d      = 1'b0;
        int_pend_d = int_pend_q;
        if (interrupt || int_pend_q) begin
          state_d    = StDrain;
          kind_d     = 1'b1;
          int_pend_d = 1'b0;
        end else if (rti) begin
          state_d = StPop;
          kind_d  = 1'b1;
        end else if (ret) begin
          state_d = RetSkipsWait ? StPop : StWait;
          kind_d  = 1'b0;
        end else if (call) begin
          state_d = StPush;
          kind_d  = 1'b0;
        end
      end
      StDrain: begin
        if (cnt_q == 5'd0) ext_d = ldm | load_use;
        if (cnt_q == drain_last) begin
          state_d = StPush;
          cnt_d   = 5'd0;
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StPop;
          cnt_d   = 5'd0;
        end
      end
      StPush, StPop: begin
        if (cnt_q == (kind_q ? CcrLast : PcLast)) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 5'd0;
        kind_d  = 1'b0;
        ext_d   = 1'b0;
      end
    endcase
  end

  // Output decode from registered state and counter
  always_comb begin
    ack       = 1'b0;
    stack     = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    push_sel  = '0;
    pop_sel   = '0;
    freeze_pc = 1'b0;
    freeze_cu = 1'b0;
    pc_sel    = 2'b00;
    flush     = 1'b0;
    busy      = (state_q != StIdle);
    case (state_q)
      StDrain: begin
        ack       = (cnt_q == 5'd0);
        // A branch resolving in the ack cycle must still redirect fetch
        freeze_pc = (cnt_q == 5'd0) ? ~branch_taken : 1'b1;
        freeze_cu = (cnt_q != 5'd0);
      end
      StPush: begin
        stack    = 1'b1;
        mem_wr   = 1'b1;
        push_sel = SEL_W'(cnt_q + 5'd1);
        if (kind_q) begin
          freeze_pc = 1'b1;
          freeze_cu = 1'b1;
          pc_sel    = (cnt_q == CcrLast) ? 2'b10 : 2'b00;
        end else begin
          pc_sel = (cnt_q == 5'd0) ? 2'b11 : 2'b00;
          flush  = (cnt_q == PcLast);
        end
      end
      StPop: begin
        stack     = 1'b1;
        mem_rd    = 1'b1;
        freeze_pc = 1'b1;
        freeze_cu = 1'b1;
        if (kind_q) begin
          pop_sel = SEL_W'(CcrSel - cnt_q);
          pc_sel  = (cnt_q == 5'd0) ? 2'b11 : 2'b00;
        end else begin
          pop_sel = SEL_W'(PcTopSel - cnt_q);
          flush   = (cnt_q == PcLast);
        end
      end
      default: ;
    endcase
  end

endmodule
